// File: rtl/cdt_pkg.sv
// Shared definitions for the washer phase countdown timer: controller state
// codes, timer FSM encoding, BCD limits and the remaining-time record.
package cdt_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WASH       = 3'd1;
  localparam logic [2:0] ST_WASH_PAUSE = 3'd2;
  localparam logic [2:0] ST_DRY        = 3'd3;
  localparam logic [2:0] ST_DRY_PAUSE  = 3'd4;
  localparam logic [2:0] ST_PREP       = 3'd5;

  localparam logic [3:0] MAX_ONE = 4'd9;
  localparam logic [3:0] MAX_TEN = 4'd5;

  typedef enum logic [2:0] {
    T_IDLE = 3'd0,
    T_PREP = 3'd1,
    T_RUN  = 3'd2,
    T_HOLD = 3'd3,
    T_DONE = 3'd4
  } tmr_state_e;

  typedef struct packed {
    logic [3:0] hr;
    logic [3:0] ten;
    logic [3:0] one;
  } bcd_time_t;

endpackage

// File: rtl/cdt_prescaler.sv
// Unit prescaler: counts 0..TICKS_PER_UNIT-1 while run is high and emits a
// one-cycle tick at terminal count; holds its fraction while run is low.
module cdt_prescaler
  import cdt_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_UNIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && !clear && (cnt_q == TERM);

endmodule

// File: rtl/cycle_countdown_timer.sv
// Washer phase countdown: loads prep/wash/dry times on phase entry, counts down
// in BCD and pulses done_op once per phase. Define CDT_PAUSE_BLINK_EN to add
// the blank output that flashes the digits while paused.
module cycle_countdown_timer
  import cdt_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000,
  parameter int unsigned PREP_UNITS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic [3:0] wash_hr,
  input  logic [3:0] wash_min_ten,
  input  logic [3:0] wash_min_one,
  input  logic [3:0] dry_hr,
  input  logic [3:0] dry_min_ten,
  input  logic [3:0] dry_min_one,
  output logic       done_op,
  output logic [3:0] remain_hr,
  output logic [3:0] remain_min_ten,
  output logic [3:0] remain_min_one,
  output logic       busy
`ifdef CDT_PAUSE_BLINK_EN
  ,
  output logic       blank
`endif
);

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic bcd_time_t load_time(input logic [3:0] hr, input logic [3:0] ten,
                                          input logic [3:0] one);
    bcd_time_t r;
    r.hr  = clamp_digit(hr, MAX_ONE);
    r.ten = clamp_digit(ten, MAX_TEN);
    r.one = clamp_digit(one, MAX_ONE);
    return r;
  endfunction

  // One-unit BCD decrement with minute/hour borrows; 0:00 is a floor.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.one != 4'd0) begin
      r.one = t.one - 4'd1;
    end else if (t.ten != 4'd0) begin
      r.ten = t.ten - 4'd1;
      r.one = MAX_ONE;
    end else if (t.hr != 4'd0) begin
      r.hr  = t.hr - 4'd1;
      r.ten = MAX_TEN;
      r.one = MAX_ONE;
    end
    return r;
  endfunction

  logic [2:0]  state_q, state_d;
  tmr_state_e  fsm_q, fsm_d;
  bcd_time_t   remain_q, remain_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        change;
  logic        is_count_st;
  logic        is_pause_st;
  logic        is_resume;
  logic        presc_clear;
  logic        presc_run;
  logic        tick;
  bcd_time_t   load_val;

  assign state_d     = state;
  assign change      = (state != state_q);
  assign is_count_st = (state == ST_WASH) || (state == ST_DRY) || (state == ST_PREP);
  assign is_pause_st = (state == ST_WASH_PAUSE) || (state == ST_DRY_PAUSE);
  assign is_resume   = change &&
                       (((state == ST_WASH) && (state_q == ST_WASH_PAUSE)) ||
                        ((state == ST_DRY)  && (state_q == ST_DRY_PAUSE)));

  // A state change suppresses run, so a coincident terminal tick is dropped
  // and the prescaler keeps its fraction instead of wrapping.
  assign presc_clear = (change && is_count_st && !is_resume) ||
                       (!is_count_st && !is_pause_st);
  assign presc_run   = !change && is_count_st &&
                       ((fsm_q == T_PREP) || (fsm_q == T_RUN)) &&
                       (remain_q != '0);

  cdt_prescaler #(
    .TICKS_PER_UNIT (TICKS_PER_UNIT)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (tick)
  );

  always_comb begin
    load_val = '0;
    case (state)
      ST_PREP: load_val = '{hr: 4'd0, ten: 4'd0, one: clamp_digit(4'(PREP_UNITS), MAX_ONE)};
      ST_WASH: load_val = load_time(wash_hr, wash_min_ten, wash_min_one);
      ST_DRY:  load_val = load_time(dry_hr, dry_min_ten, dry_min_one);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    fsm_d    = fsm_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (!is_count_st && !is_pause_st) begin
      remain_d = '0;
      fsm_d    = T_IDLE;
    end else if (is_pause_st) begin
      fsm_d = T_HOLD;
    end else if (change) begin
      if (is_resume) begin
        fsm_d = (remain_q == '0) ? T_DONE : T_RUN;
      end else begin
        remain_d = load_val;
        fsm_d    = (state == ST_PREP) ? T_PREP : T_RUN;
      end
    end else if ((fsm_q == T_PREP) || (fsm_q == T_RUN)) begin
      // Reaching 0:00 is observed one cycle later, giving the pulse its delay.
      if (remain_q == '0) begin
        done_d = 1'b1;
        fsm_d  = T_DONE;
      end else if (tick) begin
        remain_d = bcd_dec(remain_q);
      end
    end
    busy_d = (fsm_d == T_PREP) || (fsm_d == T_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      fsm_q    <= T_IDLE;
      remain_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fsm_q    <= fsm_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign done_op        = done_q;
  assign busy           = busy_q;
  assign remain_hr      = remain_q.hr;
  assign remain_min_ten = remain_q.ten;
  assign remain_min_one = remain_q.one;

`ifdef CDT_PAUSE_BLINK_EN
  localparam int unsigned HALF  = (TICKS_PER_UNIT >= 2) ? (TICKS_PER_UNIT / 2) : 1;
  localparam int unsigned BL_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BL_W-1:0] BL_TERM = BL_W'(HALF - 1);

  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blank_q, blank_d;

  always_comb begin
    blink_cnt_d = '0;
    blank_d     = 1'b0;
    if ((fsm_d == T_HOLD) && (fsm_q == T_HOLD)) begin
      blank_d = blank_q;
      if (blink_cnt_q == BL_TERM) begin
        blink_cnt_d = '0;
        blank_d     = !blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_cycle_countdown_timer.sv
// Directed bench for cycle_countdown_timer with TICKS_PER_UNIT=4, PREP_UNITS=3.
module tb_cycle_countdown_timer;

  logic       clk;
  logic       reset;
  logic [2:0] state;
  logic [3:0] wash_hr, wash_min_ten, wash_min_one;
  logic [3:0] dry_hr, dry_min_ten, dry_min_one;
  logic       done_op;
  logic [3:0] remain_hr, remain_min_ten, remain_min_one;
  logic       busy;
`ifdef CDT_PAUSE_BLINK_EN
  logic       blank;
`endif
  logic [11:0] rem;

  int errors = 0;
  int checks = 0;

  assign rem = {remain_hr, remain_min_ten, remain_min_one};

  cycle_countdown_timer #(
    .TICKS_PER_UNIT (4),
    .PREP_UNITS     (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .wash_hr        (wash_hr),
    .wash_min_ten   (wash_min_ten),
    .wash_min_one   (wash_min_one),
    .dry_hr         (dry_hr),
    .dry_min_ten    (dry_min_ten),
    .dry_min_one    (dry_min_one),
    .done_op        (done_op),
    .remain_hr      (remain_hr),
    .remain_min_ten (remain_min_ten),
    .remain_min_one (remain_min_one),
    .busy           (busy)
`ifdef CDT_PAUSE_BLINK_EN
    ,
    .blank          (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick_n(2);
    checks++;
    if (rem !== 12'h000 || busy !== 1'b0 || done_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: remain=%h busy=%b done=%b expected 000 0 0", rem, busy, done_op);
    end
    reset = 1'b1;
    tick_n(2);
    checks++;
    if (rem !== 12'h000 || busy !== 1'b0 || done_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: remain=%h busy=%b done=%b expected 000 0 0", rem, busy, done_op);
    end
  endtask

  task automatic test_prepare();
    int pulses;
    state = 3'd5;
    tick_n(1);
    checks++;
    if (rem !== 12'h003 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prep_load: remain=%h busy=%b expected 003 1", rem, busy);
    end
    tick_n(3);
    checks++;
    if (rem !== 12'h003) begin
      errors++;
      $display("FAIL prep_hold_unit: remain=%h expected 003", rem);
    end
    tick_n(1);
    checks++;
    if (rem !== 12'h002) begin
      errors++;
      $display("FAIL prep_dec1: remain=%h expected 002", rem);
    end
    tick_n(4);
    checks++;
    if (rem !== 12'h001) begin
      errors++;
      $display("FAIL prep_dec2: remain=%h expected 001", rem);
    end
    tick_n(4);
    checks++;
    if (rem !== 12'h000 || done_op !== 1'b0) begin
      errors++;
      $display("FAIL prep_zero: remain=%h done=%b expected 000 0", rem, done_op);
    end
    tick_n(1);
    checks++;
    if (done_op !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prep_done_pulse: done=%b busy=%b expected 1 0", done_op, busy);
    end
    pulses = 0;
    repeat (10) begin
      tick_n(1);
      if (done_op) pulses++;
    end
    checks++;
    if (pulses != 0 || rem !== 12'h000) begin
      errors++;
      $display("FAIL prep_single_pulse: extra_pulses=%0d remain=%h expected 0 000", pulses, rem);
    end
  endtask

  task automatic test_borrow();
    int pulses;
    wash_hr = 4'd1; wash_min_ten = 4'd0; wash_min_one = 4'd0;
    state = 3'd1;
    tick_n(1);
    checks++;
    if (rem !== 12'h100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL borrow_load: remain=%h busy=%b expected 100 1", rem, busy);
    end
    tick_n(4);
    checks++;
    if (rem !== 12'h059) begin
      errors++;
      $display("FAIL borrow_hr: remain=%h expected 059", rem);
    end
    tick_n(36);
    checks++;
    if (rem !== 12'h050) begin
      errors++;
      $display("FAIL borrow_mid: remain=%h expected 050", rem);
    end
    tick_n(4);
    checks++;
    if (rem !== 12'h049) begin
      errors++;
      $display("FAIL borrow_ten: remain=%h expected 049", rem);
    end
    pulses = 0;
    repeat (196) begin
      tick_n(1);
      if (done_op) pulses++;
    end
    checks++;
    if (rem !== 12'h000 || pulses != 0) begin
      errors++;
      $display("FAIL borrow_end: remain=%h early_pulses=%0d expected 000 0", rem, pulses);
    end
    tick_n(1);
    checks++;
    if (done_op !== 1'b1) begin
      errors++;
      $display("FAIL borrow_done: done=%b expected 1", done_op);
    end
    tick_n(1);
    checks++;
    if (done_op !== 1'b0) begin
      errors++;
      $display("FAIL borrow_done_width: done=%b expected 0", done_op);
    end
  endtask

  task automatic test_zero_dry();
    int pulses;
    dry_hr = 4'd0; dry_min_ten = 4'd0; dry_min_one = 4'd0;
    state = 3'd3;
    tick_n(1);
    checks++;
    if (rem !== 12'h000 || done_op !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_load: remain=%h done=%b busy=%b expected 000 0 1", rem, done_op, busy);
    end
    tick_n(1);
    checks++;
    if (done_op !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b expected 1 0", done_op, busy);
    end
    pulses = 0;
    repeat (20) begin
      tick_n(1);
      if (done_op) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL zero_no_repeat: extra_pulses=%0d expected 0", pulses);
    end
  endtask

  task automatic test_pause_resume();
    int pulses;
    state = 3'd5;
    tick_n(2);
    wash_hr = 4'd0; wash_min_ten = 4'd0; wash_min_one = 4'd5;
    state = 3'd1;
    tick_n(1);
    checks++;
    if (rem !== 12'h005) begin
      errors++;
      $display("FAIL pause_load: remain=%h expected 005", rem);
    end
    tick_n(10);
    checks++;
    if (rem !== 12'h003) begin
      errors++;
      $display("FAIL pause_before: remain=%h expected 003", rem);
    end
    state = 3'd2;
    tick_n(1);
    checks++;
    if (rem !== 12'h003 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: remain=%h busy=%b expected 003 0", rem, busy);
    end
    pulses = 0;
    repeat (20) begin
      tick_n(1);
      if (done_op) pulses++;
    end
    checks++;
    if (rem !== 12'h003 || pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_frozen: remain=%h pulses=%0d busy=%b expected 003 0 0", rem, pulses, busy);
    end
    state = 3'd1;
    tick_n(1);
    checks++;
    if (rem !== 12'h003 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resume_enter: remain=%h busy=%b expected 003 1", rem, busy);
    end
    tick_n(1);
    checks++;
    if (rem !== 12'h003) begin
      errors++;
      $display("FAIL resume_fraction: remain=%h expected 003", rem);
    end
    tick_n(1);
    checks++;
    if (rem !== 12'h002) begin
      errors++;
      $display("FAIL resume_dec: remain=%h expected 002", rem);
    end
  endtask

  task automatic test_clamp();
    state = 3'd5;
    tick_n(1);
    wash_hr = 4'd11; wash_min_ten = 4'd7; wash_min_one = 4'd12;
    state = 3'd1;
    tick_n(1);
    checks++;
    if (rem !== 12'h959) begin
      errors++;
      $display("FAIL clamp_load: remain=%h expected 959", rem);
    end
  endtask

  task automatic test_abort();
    int pulses;
    state = 3'd5;
    tick_n(1);
    wash_hr = 4'd0; wash_min_ten = 4'd4; wash_min_one = 4'd2;
    state = 3'd1;
    tick_n(1);
    checks++;
    if (rem !== 12'h042) begin
      errors++;
      $display("FAIL abort_load: remain=%h expected 042", rem);
    end
    tick_n(6);
    checks++;
    if (rem !== 12'h041) begin
      errors++;
      $display("FAIL abort_running: remain=%h expected 041", rem);
    end
    state = 3'd0;
    tick_n(1);
    checks++;
    if (rem !== 12'h000 || busy !== 1'b0 || done_op !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: remain=%h busy=%b done=%b expected 000 0 0", rem, busy, done_op);
    end
    pulses = 0;
    repeat (5) begin
      tick_n(1);
      if (done_op) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_pulse: pulses=%0d expected 0", pulses);
    end
    state = 3'd5;
    tick_n(1);
    wash_hr = 4'd0; wash_min_ten = 4'd3; wash_min_one = 4'd0;
    state = 3'd1;
    tick_n(2);
    dry_hr = 4'd0; dry_min_ten = 4'd2; dry_min_one = 4'd5;
    state = 3'd3;
    tick_n(3);
    checks++;
    if (rem !== 12'h025 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dry_running: remain=%h busy=%b expected 025 1", rem, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rem !== 12'h000 || busy !== 1'b0 || done_op !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: remain=%h busy=%b done=%b expected 000 0 0", rem, busy, done_op);
    end
    state = 3'd0;
    #3;
    reset = 1'b1;
    tick_n(2);
    checks++;
    if (rem !== 12'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: remain=%h busy=%b expected 000 0", rem, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    state = 3'd0;
    wash_hr = 4'd0; wash_min_ten = 4'd0; wash_min_one = 4'd0;
    dry_hr = 4'd0;  dry_min_ten = 4'd0;  dry_min_one = 4'd0;
    test_reset();
    test_prepare();
    test_borrow();
    test_zero_dry();
    test_pause_resume();
    test_clamp();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
